// File: rtl/pc_sequencer.sv
// Program-counter sequencer with jump/call/ret/branch selection and a return-address stack.
// Define PC_SEQUENCER_RAS_WRAP_EN to make the stack circular (overwrite oldest on overflow).
module pc_sequencer #(
   parameter int unsigned         XLEN        = 19,
   parameter int unsigned         RAS_DEPTH   = 8,
   parameter int unsigned         INSTR_BYTES = 4,
   parameter logic [XLEN-1:0]     RESET_PC    = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic             jump,
   input  logic             call,
   input  logic             ret,
   input  logic             branch,
   input  logic [2:0]       funct3,
   input  logic             zero,
   input  logic             neg,
   input  logic [XLEN-1:0]  target,
   output logic [XLEN-1:0]  pc,
   output logic [XLEN-1:0]  pc_plus,
   output logic             ras_empty,
   output logic             ras_full,
   output logic             ras_err
);

   localparam int unsigned AW = $clog2(RAS_DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [XLEN-1:0] pc_q, pc_d;
   logic [CW-1:0]   count_q, count_d;
   logic [AW-1:0]   ptr_q, ptr_d, ptr_m1;
   logic            err_q, err_d;
   logic [XLEN-1:0] ras_mem [RAS_DEPTH];
   logic [XLEN-1:0] tos;
   logic            taken, push_ok, pop_ok, ret_empty, push_drop;

   assign pc_plus   = pc_q + XLEN'(INSTR_BYTES);
   assign ras_empty = (count_q == '0);
   assign ras_full  = (count_q == CW'(RAS_DEPTH));
   assign ptr_m1    = ptr_q - AW'(1);
   assign tos       = ras_mem[ptr_m1];
   assign pc        = pc_q;
   assign ras_err   = err_q;

   always_comb begin
      taken = branch & (((funct3 == 3'b000) & zero) | ((funct3 == 3'b001) & ~zero) |
                        ((funct3 == 3'b100) & neg)  | ((funct3 == 3'b101) & ~neg));

      // ret only acts when no jump/call competes in the same cycle
      pop_ok    = ret & ~jump & ~call & ~ras_empty;
      ret_empty = ret & ~jump & ~call & ras_empty;
`ifdef PC_SEQUENCER_RAS_WRAP_EN
      push_ok   = call;
      push_drop = 1'b0;
`else
      push_ok   = call & ~ras_full;
      push_drop = call & ras_full;
`endif

      pc_d = pc_plus;
      if (jump | call)
         pc_d = target;
      else if (pop_ok)
         pc_d = tos;
      else if (taken)
         pc_d = target;

      count_d = count_q;
      ptr_d   = ptr_q;
      if (push_ok) begin
         ptr_d = ptr_q + AW'(1);
         if (!ras_full)
            count_d = count_q + CW'(1);
      end else if (pop_ok) begin
         ptr_d   = ptr_m1;
         count_d = count_q - CW'(1);
      end

      err_d = err_q | ret_empty | push_drop;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q    <= RESET_PC;
         count_q <= '0;
         ptr_q   <= '0;
         err_q   <= 1'b0;
      end else if (!stall) begin
         pc_q    <= pc_d;
         count_q <= count_d;
         ptr_q   <= ptr_d;
         err_q   <= err_d;
      end
   end

   // Entries carry no reset; they are only read once the count says they were written.
   always_ff @(posedge clk) begin
      if (!rst && !stall && push_ok)
         ras_mem[ptr_q] <= pc_plus;
   end

endmodule
